// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state, mux-select and opcode constants for the calculator control unit
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_X   = 3'd1,
        ST_WAIT_Y   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_WAIT_ALU = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

    // Low field of s when its MSB is 1 (load paths); MSB 0 means s carries the opcode.
    localparam int S_LDX  = 0;
    localparam int S_LDY  = 1;
    localparam int S_LDZX = 2;

    localparam int ADD = 0;
    localparam int SUB = 1;
    localparam int MUL = 2;
    localparam int DIV = 3;

endpackage

// File: rtl/calc_cu_seq_if.sv
// rtl/calc_cu_seq_if.sv - control/status bundle between the sequencer and its datapath
interface calc_cu_seq_if #(
    parameter int SEL_W = 2
);
    localparam int S_W = SEL_W + 1;

    logic             start_x;
    logic             start_y;
    logic             chain;
    logic [SEL_W-1:0] sel;
    logic             y_zero;
    logic             alu_ack;
    logic             abort;
    logic             clr_err;

    logic [2:0]       y;
    logic [S_W-1:0]   s;
    logic             ld_x, clr_x, ld_y, clr_y, ld_z, clr_z;
    logic             alu_go;
    logic             done;
    logic             err;
    logic             busy;

    modport master (
        output start_x, start_y, chain, sel, y_zero, alu_ack, abort, clr_err,
        input  y, s, ld_x, clr_x, ld_y, clr_y, ld_z, clr_z, alu_go, done, err, busy
    );

    modport slave (
        input  start_x, start_y, chain, sel, y_zero, alu_ack, abort, clr_err,
        output y, s, ld_x, clr_x, ld_y, clr_y, ld_z, clr_z, alu_go, done, err, busy
    );

endinterface

// File: rtl/calc_timeout_ctr.sv
// rtl/calc_timeout_ctr.sv - clearable cycle counter flagging the last allowed wait cycle
module calc_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/calc_cu_seq.sv
// rtl/calc_cu_seq.sv - operand load / execute sequencer with result chaining, multi-cycle ALU handshake and error state
module calc_cu_seq
    import calc_pkg::*;
#(
    parameter int                     SEL_W   = 2,
    parameter logic [(1<<SEL_W)-1:0]  MC_MASK = 4'b1000,
    parameter int                     DIV_OP  = DIV,
    parameter int                     TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    calc_cu_seq_if.slave   bus
);
    localparam int S_W = SEL_W + 1;
    localparam logic [S_W-1:0] S_DEF  = {1'b1, SEL_W'(S_LDX)};
    localparam logic [S_W-1:0] S_Y    = {1'b1, SEL_W'(S_LDY)};
    localparam logic [S_W-1:0] S_ZX   = {1'b1, SEL_W'(S_LDZX)};

    state_t           state, state_nxt;
    logic [SEL_W-1:0] op_q;
    logic             z_valid;
    logic             op_ld, zv_set, zv_clr;
    logic             tmr_clr, tmr_exp;

    calc_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (state == ST_WAIT_ALU),
        .expire (tmr_exp)
    );

    assign bus.y = state;

    always_comb begin
        state_nxt  = state;
        bus.s      = S_DEF;
        bus.ld_x   = 1'b0;
        bus.clr_x  = 1'b0;
        bus.ld_y   = 1'b0;
        bus.clr_y  = 1'b0;
        bus.ld_z   = 1'b0;
        bus.clr_z  = 1'b0;
        bus.alu_go = 1'b0;
        bus.done   = 1'b0;
        bus.err    = 1'b0;
        bus.busy   = 1'b0;
        op_ld      = 1'b0;
        zv_set     = 1'b0;
        zv_clr     = 1'b0;
        tmr_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.clr_x = 1'b1;
                bus.clr_y = 1'b1;
                bus.clr_z = 1'b1;
                zv_clr    = 1'b1;
                state_nxt = ST_WAIT_X;
            end
            ST_WAIT_X: begin
                if (bus.start_x) begin
                    bus.ld_x  = 1'b1;
                    state_nxt = ST_WAIT_Y;
                end else if (bus.chain && z_valid) begin
                    bus.ld_x  = 1'b1;
                    bus.s     = S_ZX;
                    state_nxt = ST_WAIT_Y;
                end
            end
            ST_WAIT_Y: begin
                if (bus.start_y) begin
                    bus.ld_y  = 1'b1;
                    bus.s     = S_Y;
                    op_ld     = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                bus.s    = {1'b0, op_q};
                bus.busy = 1'b1;
                if (op_q == SEL_W'(DIV_OP) && bus.y_zero) begin
                    state_nxt = ST_ERR;
                end else if (MC_MASK[op_q]) begin
                    bus.alu_go = 1'b1;
                    tmr_clr    = 1'b1;
                    state_nxt  = ST_WAIT_ALU;
                end else begin
                    bus.ld_z  = 1'b1;
                    bus.done  = 1'b1;
                    zv_set    = 1'b1;
                    state_nxt = ST_WAIT_X;
                end
            end
            ST_WAIT_ALU: begin
                bus.s    = {1'b0, op_q};
                bus.busy = 1'b1;
                // An ack on the final allowed cycle still wins over the timeout.
                if (bus.alu_ack) begin
                    bus.ld_z  = 1'b1;
                    bus.done  = 1'b1;
                    zv_set    = 1'b1;
                    state_nxt = ST_WAIT_X;
                end else if (tmr_exp) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                bus.err   = 1'b1;
                bus.clr_z = 1'b1;
                zv_clr    = 1'b1;
                if (bus.clr_err || bus.abort) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort squelches every side effect except the IDLE and ERR decodes.
        if (bus.abort && state != ST_ERR) begin
            state_nxt = ST_IDLE;
            if (state != ST_IDLE) begin
                bus.ld_x   = 1'b0;
                bus.clr_x  = 1'b0;
                bus.ld_y   = 1'b0;
                bus.clr_y  = 1'b0;
                bus.ld_z   = 1'b0;
                bus.clr_z  = 1'b0;
                bus.alu_go = 1'b0;
                bus.done   = 1'b0;
                op_ld      = 1'b0;
                zv_set     = 1'b0;
                zv_clr     = 1'b0;
                tmr_clr    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            z_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (op_ld) begin
                op_q <= bus.sel;
            end
            if (zv_set) begin
                z_valid <= 1'b1;
            end else if (zv_clr) begin
                z_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_cu_seq.sv
// tb/tb_calc_cu_seq.sv - directed table, corner sequences and randomized model check for calc_cu_seq
module tb_calc_cu_seq;

    localparam int TIMEOUT = 16;
    localparam int DIV_OP  = 3;
    localparam int MC_OP   = 3;

    localparam logic [9:0] IDL = 10'b0101010000;
    localparam logic [9:0] NO  = 10'b0000000000;
    localparam logic [9:0] LDX = 10'b1000000000;
    localparam logic [9:0] LDY = 10'b0010000000;
    localparam logic [9:0] DN  = 10'b0000100101;
    localparam logic [9:0] BSY = 10'b0000000001;
    localparam logic [9:0] GO  = 10'b0000001001;
    localparam logic [9:0] ER  = 10'b0000010010;

    logic clk = 1'b0;
    logic rst = 1'b0;

    calc_cu_seq_if #(.SEL_W(2)) bus ();

    calc_cu_seq #(.SEL_W(2), .MC_MASK(4'b1000), .DIV_OP(DIV_OP), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       start_x;
        logic       start_y;
        logic       chain;
        logic [1:0] sel;
        logic       y_zero;
        logic       alu_ack;
        logic       abort;
        logic       clr_err;
    } in_t;

    typedef struct {
        in_t        i;
        logic [2:0] y;
        logic [2:0] s;
        logic [9:0] strb;
    } vec_t;

    vec_t tbl[$];

    // Reference model: phase of the operation, latched opcode, whether Z holds a result, cycles spent waiting.
    int m_ph, m_op, m_wait;
    bit m_zv;
    int n_ph, n_op, n_wait;
    bit n_zv;

    function automatic in_t mk(bit sx, bit sy, bit ch, int sel, bit yz, bit ack, bit ab, bit ce);
        in_t r;
        r.start_x = sx;
        r.start_y = sy;
        r.chain   = ch;
        r.sel     = 2'(sel);
        r.y_zero  = yz;
        r.alu_ack = ack;
        r.abort   = ab;
        r.clr_err = ce;
        return r;
    endfunction

    task automatic add(in_t i, logic [2:0] y, logic [2:0] s, logic [9:0] strb);
        vec_t v;
        v.i = i;
        v.y = y;
        v.s = s;
        v.strb = strb;
        tbl.push_back(v);
    endtask

    task automatic drive(in_t i);
        bus.start_x = i.start_x;
        bus.start_y = i.start_y;
        bus.chain   = i.chain;
        bus.sel     = i.sel;
        bus.y_zero  = i.y_zero;
        bus.alu_ack = i.alu_ack;
        bus.abort   = i.abort;
        bus.clr_err = i.clr_err;
    endtask

    function automatic logic [15:0] dut_out();
        return {bus.y, bus.s, bus.ld_x, bus.clr_x, bus.ld_y, bus.clr_y, bus.ld_z, bus.clr_z,
                bus.alu_go, bus.done, bus.err, bus.busy};
    endfunction

    task automatic check(string name, logic [15:0] got, logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got y=%0d s=%b strobes=%b, expected y=%0d s=%b strobes=%b",
                     name, got[15:13], got[12:10], got[9:0], exp[15:13], exp[12:10], exp[9:0]);
        end
    endtask

    task automatic check_bit(string name, logic got, logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_op = 0; m_wait = 0; m_zv = 0;
    endtask

    task automatic model_eval(input in_t i, output logic [15:0] o);
        logic [2:0] s;
        logic ldx, clx, ldy, cly, ldz, clz, go, dn, er, bz;
        s = 3'b100;
        {ldx, clx, ldy, cly, ldz, clz, go, dn, er, bz} = '0;
        n_ph = m_ph; n_op = m_op; n_wait = m_wait; n_zv = m_zv;
        case (m_ph)
            0: begin clx = 1; cly = 1; clz = 1; n_zv = 0; n_ph = 1; end
            1: begin
                if (i.start_x) begin ldx = 1; n_ph = 2; end
                else if (i.chain && m_zv) begin ldx = 1; s = 3'b110; n_ph = 2; end
            end
            2: if (i.start_y) begin ldy = 1; s = 3'b101; n_op = int'(i.sel); n_ph = 3; end
            3: begin
                s = 3'(m_op); bz = 1;
                if (m_op == DIV_OP && i.y_zero) n_ph = 5;
                else if (m_op == MC_OP) begin go = 1; n_wait = 0; n_ph = 4; end
                else begin ldz = 1; dn = 1; n_zv = 1; n_ph = 1; end
            end
            4: begin
                s = 3'(m_op); bz = 1; n_wait = m_wait + 1;
                if (i.alu_ack) begin ldz = 1; dn = 1; n_zv = 1; n_ph = 1; end
                else if (m_wait == TIMEOUT - 1) n_ph = 5;
            end
            default: begin
                er = 1; clz = 1; n_zv = 0;
                if (i.clr_err || i.abort) n_ph = 0;
            end
        endcase
        if (i.abort && m_ph != 5) begin
            n_ph = 0;
            if (m_ph != 0) begin
                {ldx, clx, ldy, cly, ldz, clz, go, dn} = '0;
                n_op = m_op; n_zv = m_zv; n_wait = m_wait;
            end
        end
        o = {3'(m_ph), s, ldx, clx, ldy, cly, ldz, clz, go, dn, er, bz};
    endtask

    // One clock: drive at negedge, compare settled Mealy outputs, advance the model at posedge.
    task automatic cycle(input in_t i, input bit use_tbl, input logic [15:0] texp,
                         input string name, output logic [15:0] got);
        logic [15:0] m;
        @(negedge clk);
        drive(i);
        #1;
        model_eval(i, m);
        got = dut_out();
        if (use_tbl) check(name, got, texp);
        else check(name, got, m);
        @(posedge clk);
        m_ph = n_ph; m_op = n_op; m_wait = n_wait; m_zv = n_zv;
    endtask

    function automatic in_t rnd_in();
        in_t r;
        r.start_x = ($urandom_range(0, 99) < 30);
        r.start_y = ($urandom_range(0, 99) < 35);
        r.chain   = ($urandom_range(0, 99) < 40);
        r.sel     = 2'($urandom_range(0, 3));
        r.y_zero  = ($urandom_range(0, 99) < 30);
        r.alu_ack = ($urandom_range(0, 99) < 12);
        r.abort   = ($urandom_range(0, 99) < 4);
        r.clr_err = ($urandom_range(0, 99) < 30);
        return r;
    endfunction

    initial begin
        logic [15:0] got;
        in_t z, sx, sy3, ack;
        z   = mk(0, 0, 0, 0, 0, 0, 0, 0);
        sx  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        sy3 = mk(0, 1, 0, 3, 0, 0, 0, 0);
        ack = mk(0, 0, 0, 0, 0, 1, 0, 0);

        add(z,                          3'd0, 3'b100, IDL);
        add(sx,                         3'd1, 3'b100, LDX);
        add(mk(0, 1, 0, 0, 0, 0, 0, 0), 3'd2, 3'b101, LDY);
        add(z,                          3'd3, 3'b000, DN);
        add(mk(0, 0, 1, 0, 0, 0, 0, 0), 3'd1, 3'b110, LDX);
        add(mk(0, 1, 0, 1, 0, 0, 0, 0), 3'd2, 3'b101, LDY);
        add(z,                          3'd3, 3'b001, DN);
        add(z,                          3'd1, 3'b100, NO);
        add(sx,                         3'd1, 3'b100, LDX);
        add(z,                          3'd2, 3'b100, NO);
        add(mk(0, 1, 0, 3, 1, 0, 0, 0), 3'd2, 3'b101, LDY);
        add(mk(0, 0, 0, 0, 1, 0, 0, 0), 3'd3, 3'b011, BSY);
        add(z,                          3'd5, 3'b100, ER);
        add(mk(0, 0, 0, 0, 0, 0, 0, 1), 3'd5, 3'b100, ER);
        add(z,                          3'd0, 3'b100, IDL);
        add(mk(0, 0, 1, 0, 0, 0, 0, 0), 3'd1, 3'b100, NO);
        add(sx,                         3'd1, 3'b100, LDX);
        add(sy3,                        3'd2, 3'b101, LDY);
        add(z,                          3'd3, 3'b011, GO);
        for (int k = 0; k < 5; k++) add(z, 3'd4, 3'b011, BSY);
        add(ack,                        3'd4, 3'b011, DN);
        add(sx,                         3'd1, 3'b100, LDX);
        add(sy3,                        3'd2, 3'b101, LDY);
        add(z,                          3'd3, 3'b011, GO);
        add(z,                          3'd4, 3'b011, BSY);
        add(mk(0, 0, 0, 0, 0, 1, 1, 0), 3'd4, 3'b011, BSY);
        add(z,                          3'd0, 3'b100, IDL);

        drive(z);
        model_reset();
        #3;
        check("reset_idle", dut_out(), {3'd0, 3'b100, IDL});
        @(posedge clk);
        #2;
        check("reset_held", dut_out(), {3'd0, 3'b100, IDL});
        rst = 1'b1;

        foreach (tbl[k]) begin
            cycle(tbl[k].i, 1'b1, {tbl[k].y, tbl[k].s, tbl[k].strb}, $sformatf("vec%0d", k), got);
        end

        // Timeout: no ack across all allowed wait cycles.
        cycle(sx, 0, '0, "to_ldx", got);
        cycle(sy3, 0, '0, "to_ldy", got);
        cycle(z, 0, '0, "to_exec", got);
        for (int k = 0; k < TIMEOUT; k++) cycle(z, 0, '0, "to_wait", got);
        cycle(z, 0, '0, "to_err", got);
        check_bit("timeout_err_flag", got[1], 1'b1);
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 1), 0, '0, "to_clr", got);
        cycle(z, 0, '0, "to_idle", got);
        check_bit("timeout_back_idle", got[15:13] == 3'd0, 1'b1);

        // Ack on the last allowed wait cycle is a success.
        cycle(sx, 0, '0, "lim_ldx", got);
        cycle(sy3, 0, '0, "lim_ldy", got);
        cycle(z, 0, '0, "lim_exec", got);
        for (int k = 0; k < TIMEOUT - 1; k++) cycle(z, 0, '0, "lim_wait", got);
        cycle(ack, 0, '0, "lim_ack", got);
        check_bit("ack_at_limit_done", got[2], 1'b1);
        cycle(z, 0, '0, "lim_after", got);
        check_bit("ack_at_limit_wait_x", got[15:13] == 3'd1, 1'b1);

        // Asynchronous reset while waiting for Y.
        cycle(sx, 0, '0, "ar_ldx", got);
        drive(z);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_idle", dut_out(), {3'd0, 3'b100, IDL});
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            cycle(rnd_in(), 0, '0, "random", got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_cu_seq.md
Name: calc_cu_seq

Overview:
- Parametrised control unit for the calculator datapath; successor to the fixed 2-bit-select, 4-state sequencer.
- Sequences operand-X load, operand-Y load and execute; drives register load/clear strobes and the datapath mux/ALU select `s`.
- Adds:
  - result chaining (Z fed back into X);
  - multi-cycle ops with an ALU go/ack handshake and timeout;
  - divide-by-zero error state;
  - synchronous abort.

Parameters:
- SEL_W, 2, width of operation select; S_W = SEL_W+1 (derived localparam).
- MC_MASK, 4'b1000, bit i set = opcode i is multi-cycle (uses alu_go/alu_ack).
- DIV_OP, 3, opcode checked against y_zero for divide-by-zero.
- TIMEOUT, 16, max cycles waiting for alu_ack before error; counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_x  in  1  operand X present on input bus.
- start_y  in  1  operand Y present on input bus.
- chain  in  1  load previous result Z into X instead of bus.
- sel  in  SEL_W  operation select, sampled at Y load.
- y_zero  in  1  datapath flag: Y register == 0.
- alu_ack  in  1  multi-cycle ALU result ready (1-cycle pulse).
- abort  in  1  synchronous return to IDLE.
- clr_err  in  1  leave ERR state.
- y  out  3  current state (debug).
- s  out  S_W  datapath mux/ALU select.
- ld_x, clr_x, ld_y, clr_y, ld_z, clr_z  out  1 each  register strobes.
- alu_go  out  1  start multi-cycle op (1-cycle pulse).
- done  out  1  result written (1-cycle pulse).
- err  out  1  error state flag.
- busy  out  1  high in EXEC and WAIT_ALU.

Behaviour:
- Registers:
  - state: 3 bits, async-cleared to IDLE when rst=0.
  - op_q: SEL_W bits, reset 0.
  - z_valid: reset 0.
  - tmr: reset 0.
- Outputs are combinational from state and inputs, Mealy as listed. Every strobe defaults to 0; s defaults to {1'b1,0}.
- With rst=0, outputs equal the IDLE decode.
- States:
  - IDLE=0
  - WAIT_X=1
  - WAIT_Y=2
  - EXEC=3
  - WAIT_ALU=4
  - ERR=5
  - 6 and 7 are illegal and return to IDLE.
- Priority: abort=1 in any state except ERR forces next=IDLE; no strobes other than IDLE decode.
- IDLE:
  - clr_x=clr_y=clr_z=1, s={1,0..0}, z_valid<=0.
  - Next WAIT_X unconditionally.
- WAIT_X:
  - start_x=1: ld_x=1, s={1,0..0}, next WAIT_Y.
  - Else chain=1 and z_valid=1: ld_x=1, s={1,0..010} (Z path), next WAIT_Y.
  - chain with z_valid=0 is ignored.
  - Otherwise hold.
  - start_x has priority over chain.
- WAIT_Y:
  - start_y=1: ld_y=1, s={1,0..01}, op_q<=sel, next EXEC.
  - Otherwise hold (no return to WAIT_X).
- EXEC:
  - s={0,op_q}, busy=1.
  - If op_q==DIV_OP and y_zero: next ERR, no ld_z.
  - Else if MC_MASK[op_q]: alu_go=1, tmr<=0, next WAIT_ALU.
  - Else ld_z=1, done=1, z_valid<=1, next WAIT_X.
  - Latency: start_y cycle to done is exactly 1 cycle for single-cycle ops.
- WAIT_ALU:
  - s={0,op_q} held, busy=1, tmr increments.
  - alu_ack=1: ld_z=1, done=1, z_valid<=1, next WAIT_X. An ack on the same cycle tmr reaches TIMEOUT-1 counts as success.
  - tmr==TIMEOUT-1 without ack: next ERR.
  - alu_ack outside WAIT_ALU is ignored.
- ERR:
  - err=1, clr_z=1, z_valid<=0.
  - Stays until clr_err=1, then next IDLE.
  - abort also exits to IDLE.
- Reset mid-operation: immediate async return to IDLE; op_q and z_valid cleared; no done.
- Simultaneous abort+alu_ack in WAIT_ALU: abort wins, no ld_z/done.

Decomposition:
- Package calc_pkg:
  - state enum/localparams;
  - s-encoding constants S_LDX, S_LDY, S_LDZX;
  - opcode constants ADD=0, SUB=1, MUL=2, DIV=3.
- Sub-module calc_timeout_ctr: clear/enable/expire counter, parametrised TIMEOUT. Otherwise a single module.

Test Plan:
- Reset release, start_x pulse, then start_y with sel=0 → ld_x, then ld_y with s=3'b101, next cycle ld_z=1, done=1, s=3'b000, y returns to 1.
- Chain: after the add completes, chain=1 with no start_x → ld_x with s=3'b110. Then start_y, sel=1 → done with s=3'b001.
- Divide by zero: sel=3 with y_zero=1 and MC_MASK bit 3 cleared → ERR, err=1, no done. clr_err=1 → IDLE, then WAIT_X.
- Multi-cycle op, MC_MASK=4'b1000, sel=3, y_zero=0 → alu_go pulse; alu_ack after 5 cycles → done. With no ack for 16 cycles → ERR.
- abort asserted in WAIT_ALU on the same cycle as alu_ack → IDLE, ld_z=0, done=0.
- rst=0 asserted in WAIT_Y between clock edges → y=0 immediately, with clr_x=clr_y=clr_z=1.
